// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline stall/flush sequencer.
// State, cause and mul/div latency defaults used by the control slice.
package pipe_ctrl_pkg;

    localparam logic [0:0] RUN     = 1'b0;
    localparam logic [0:0] MD_BUSY = 1'b1;

    localparam int MD_LATENCY_DEF = 4;

    typedef enum logic [2:0] {
        CAUSE_NONE,
        CAUSE_LOAD,
        CAUSE_BRANCH,
        CAUSE_MD,
        CAUSE_MEM
    } cause_e;

endpackage

// File: rtl/md_latency_counter.sv
// Mul/div occupancy counter: load, decrement or hold.
// last flags the final MD_BUSY cycle (count == 1).
module md_latency_counter #(
    parameter int LAT = 4,
    parameter int W   = $clog2(LAT)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         last
);

    // Load LAT-1 on start, count down while busy, hold otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= W'(LAT - 1);
        end else if (dec) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign last = (cnt == W'(1));

endmodule

// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: FSM and priority mux.
// Optional stall-cycle perf counter enabled by defining STALL_PERF_EN.
module pipeline_stall_controller
    import pipe_ctrl_pkg::*;
#(
    parameter int MD_LATENCY = MD_LATENCY_DEF,
    parameter int CNT_W      = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic LoadUse,
    input  logic BranchTaken,
    input  logic MulDivStart,
    input  logic DMemReq,
    input  logic DMemReady,
    output logic PCWrite,
    output logic IFIDWrite,
    output logic IFIDFlush,
    output logic IDEXWrite,
    output logic IDEXFlush,
    output logic EXMEMWrite,
    output logic EXMEMFlush,
    output logic MEMWBFlush,
    output logic MulDivBusy
`ifdef STALL_PERF_EN
    ,
    output logic [CNT_W-1:0] StallCycles
`endif
);

    localparam int MdW = $clog2(MD_LATENCY);

    logic [0:0]     state;
    logic [0:0]     state_nxt;
    logic           mem_wait;
    logic           md_stall;
    logic           md_load;
    logic           md_dec;
    logic           md_last;
    logic [MdW-1:0] md_cnt;
    cause_e         cause;

    assign mem_wait = DMemReq & ~DMemReady;
    assign md_stall = ((state == RUN) & MulDivStart) | (state == MD_BUSY);
    assign md_load  = (state == RUN) & MulDivStart & ~mem_wait;
    assign md_dec   = (state == MD_BUSY) & ~mem_wait;

    md_latency_counter #(
        .LAT (MD_LATENCY),
        .W   (MdW)
    ) u_md_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (md_load),
        .dec   (md_dec),
        .cnt   (md_cnt),
        .last  (md_last)
    );

    // Pick the single highest-priority active stall cause
    always_comb begin
        cause = CAUSE_NONE;
        priority case (1'b1)
            mem_wait:                          cause = CAUSE_MEM;
            md_stall:                          cause = CAUSE_MD;
            (state == RUN) && BranchTaken:     cause = CAUSE_BRANCH;
            (state == RUN) && LoadUse:         cause = CAUSE_LOAD;
            default:                           cause = CAUSE_NONE;
        endcase
    end

    // Decode cause into stage controls; reset forces bubbles everywhere
    always_comb begin
        PCWrite    = 1'b1;
        IFIDWrite  = 1'b1;
        IFIDFlush  = 1'b0;
        IDEXWrite  = 1'b1;
        IDEXFlush  = 1'b0;
        EXMEMWrite = 1'b1;
        EXMEMFlush = 1'b0;
        MEMWBFlush = 1'b0;
        unique case (cause)
            CAUSE_MEM: begin
                PCWrite    = 1'b0;
                IFIDWrite  = 1'b0;
                IDEXWrite  = 1'b0;
                EXMEMWrite = 1'b0;
                MEMWBFlush = 1'b1;
            end
            CAUSE_MD: begin
                PCWrite    = 1'b0;
                IFIDWrite  = 1'b0;
                IDEXWrite  = 1'b0;
                EXMEMFlush = 1'b1;
            end
            CAUSE_BRANCH: begin
                IFIDFlush = 1'b1;
                IDEXFlush = 1'b1;
            end
            CAUSE_LOAD: begin
                PCWrite   = 1'b0;
                IFIDWrite = 1'b0;
                IDEXFlush = 1'b1;
            end
            default: begin
            end
        endcase
        if (!rst_n) begin
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            IFIDFlush  = 1'b1;
            IDEXWrite  = 1'b0;
            IDEXFlush  = 1'b1;
            EXMEMWrite = 1'b0;
            EXMEMFlush = 1'b1;
            MEMWBFlush = 1'b1;
        end
    end

    // Next state: enter MD_BUSY on an unblocked start, leave on last count
    always_comb begin
        state_nxt = state;
        if (state == RUN) begin
            if (md_load) state_nxt = MD_BUSY;
        end else begin
            if (md_dec && md_last) state_nxt = RUN;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RUN;
        else        state <= state_nxt;
    end

    assign MulDivBusy = (state == MD_BUSY);

`ifdef STALL_PERF_EN
    // Count edges with the PC frozen, saturating at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            StallCycles <= '0;
        end else if (!PCWrite && (StallCycles != '1)) begin
            StallCycles <= StallCycles + CNT_W'(1);
        end
    end
`else
    // CNT_W only sizes the perf counter; keep it referenced when absent
    if (CNT_W < 1) begin : g_cnt_w_unused
    end
`endif

endmodule
